rv32_mod_trap_ctrl: RTL and testbench

Machine-mode trap sequencer for the rv32imc_ss core.
- Accepts synchronous exceptions, MRET and pending interrupts, picks one, and drives the CSR file's single write port through a fixed sequence: mepc, mcause, mtval, mstatus.
- Then issues a one-cycle PC redirect.
- Sits between decode/execute and `rv32_mod_csrs`, and stalls the core while the sequence runs.

---
 rtl/rv32_pkg.sv | 72 +++++++
 rtl/rv32_mod_irq_prio.sv | 32 +++
 rtl/rv32_mod_trap_ctrl.sv | 153 +++++++++++++++
 tb/tb_rv32_mod_trap_ctrl.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
// Shared types and constants for the rv32imc_ss machine-mode trap path.
// The mstatus rewrite rules live here so that every user applies the same ones.
package rv32_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_MEPC,
    ST_W_MCAUSE,
    ST_W_MTVAL,
    ST_W_MSTATUS,
    ST_M_MSTATUS,
    ST_REDIRECT
  } trap_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Bit positions in mip/mie, and the matching 4-bit cause codes
  localparam int IRQ_MSI_BIT = 3;
  localparam int IRQ_MTI_BIT = 7;
  localparam int IRQ_MEI_BIT = 11;
  localparam logic [3:0] IRQ_MSI = 4'd3;
  localparam logic [3:0] IRQ_MTI = 4'd7;
  localparam logic [3:0] IRQ_MEI = 4'd11;

  localparam logic [31:0] MCAUSE_IRQ = 32'h8000_0000;

  typedef struct packed {
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] tval;
    logic [31:0] target;
  } trap_req_t;

  function automatic logic [31:0] trap_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MPIE] = s[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // M-only core: MPP always returns to 11
  function automatic logic [31:0] mret_mstatus(input logic [31:0] s);
    logic [31:0] r;
    r = s;
    r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // MODE 10/11 fall back to direct; the vector offset wraps modulo 2^32
  function automatic logic [31:0] trap_target(input logic [31:0] mtvec, input logic is_irq,
                                              input logic [3:0] code, input logic vec_en);
    logic [31:0] base;
    base = {mtvec[31:2], 2'b00};
    if (vec_en && is_irq && (mtvec[1:0] == 2'b01))
      return base + {26'd0, code, 2'b00};
    return base;
  endfunction

endpackage

// File: rtl/rv32_mod_irq_prio.sv
// Machine interrupt picker: MEI > MSI > MTI, gated by mstatus.MIE.
module rv32_mod_irq_prio
  import rv32_pkg::*;
(
  input  logic [31:0] pending,
  input  logic        mie,
  output logic        irq_valid,
  output logic [3:0]  irq_code
);

  // Only the three machine-level sources are serviced here
  logic unused_pend;
  assign unused_pend = ^{pending[31:12], pending[10:8], pending[6:4], pending[2:0]};

  always_comb begin
    irq_valid = 1'b0;
    irq_code  = 4'd0;
    if (mie) begin
      if (pending[IRQ_MEI_BIT]) begin
        irq_valid = 1'b1;
        irq_code  = IRQ_MEI;
      end else if (pending[IRQ_MSI_BIT]) begin
        irq_valid = 1'b1;
        irq_code  = IRQ_MSI;
      end else if (pending[IRQ_MTI_BIT]) begin
        irq_valid = 1'b1;
        irq_code  = IRQ_MTI;
      end
    end
  end

endmodule

// File: rtl/rv32_mod_trap_ctrl.sv
// Machine-mode trap sequencer: serialises mepc/mcause/mtval/mstatus through the
// CSR file's single write port, then pulses a PC redirect. All outputs are registered.
module rv32_mod_trap_ctrl
  import rv32_pkg::*;
#(
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_valid,
  input  logic [3:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        mret,
  input  logic [31:0] irq_pc,
  input  logic [31:0] csr_mstatus,
  input  logic [31:0] csr_mie,
  input  logic [31:0] csr_mip,
  input  logic [31:0] csr_mtvec,
  input  logic [31:0] csr_mepc,
  output logic        csr_wr,
  output logic [11:0] csr_addr,
  output logic [31:0] csr_wdata,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        trap_taken
);

  trap_state_e state;
  logic        irq_valid;
  logic [3:0]  irq_code;
  logic [31:0] irq_pend;
  logic        take_trap;
  trap_req_t   acc;

  logic [31:0] lat_cause;
  logic [31:0] lat_tval;
  logic [31:0] lat_mstatus;
  logic [31:0] lat_target;

  assign irq_pend = csr_mip & csr_mie;

  rv32_mod_irq_prio u_irq_prio (
    .pending   (irq_pend),
    .mie       (csr_mstatus[MSTATUS_MIE]),
    .irq_valid (irq_valid),
    .irq_code  (irq_code)
  );

  // Exception beats MRET beats interrupt; MRET alone takes the other path
  assign take_trap = exc_valid | (~mret & irq_valid);

  always_comb begin
    acc = '0;
    if (exc_valid) begin
      acc.cause  = {28'd0, exc_cause};
      acc.epc    = exc_pc;
      acc.tval   = exc_tval;
      acc.target = trap_target(csr_mtvec, 1'b0, exc_cause, VECTORED_EN);
    end else begin
      acc.cause  = MCAUSE_IRQ | {28'd0, irq_code};
      acc.epc    = irq_pc;
      acc.tval   = '0;
      acc.target = trap_target(csr_mtvec, 1'b1, irq_code, VECTORED_EN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      csr_wr         <= 1'b0;
      csr_addr       <= '0;
      csr_wdata      <= '0;
      busy           <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      trap_taken     <= 1'b0;
      lat_cause      <= '0;
      lat_tval       <= '0;
      lat_mstatus    <= '0;
      lat_target     <= '0;
    end else begin
      csr_wr         <= 1'b0;
      redirect_valid <= 1'b0;
      trap_taken     <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (take_trap) begin
            lat_cause   <= acc.cause;
            lat_tval    <= acc.tval;
            lat_mstatus <= trap_mstatus(csr_mstatus);
            lat_target  <= acc.target;
            csr_wr      <= 1'b1;
            csr_addr    <= CSR_MEPC;
            csr_wdata   <= acc.epc;
            busy        <= 1'b1;
            state       <= ST_W_MEPC;
          end else if (mret) begin
            lat_target  <= csr_mepc;
            csr_wr      <= 1'b1;
            csr_addr    <= CSR_MSTATUS;
            csr_wdata   <= mret_mstatus(csr_mstatus);
            busy        <= 1'b1;
            state       <= ST_M_MSTATUS;
          end
        end
        ST_W_MEPC: begin
          csr_wr    <= 1'b1;
          csr_addr  <= CSR_MCAUSE;
          csr_wdata <= lat_cause;
          state     <= ST_W_MCAUSE;
        end
        ST_W_MCAUSE: begin
          csr_wr    <= 1'b1;
          csr_addr  <= CSR_MTVAL;
          csr_wdata <= lat_tval;
          state     <= ST_W_MTVAL;
        end
        ST_W_MTVAL: begin
          csr_wr    <= 1'b1;
          csr_addr  <= CSR_MSTATUS;
          csr_wdata <= lat_mstatus;
          state     <= ST_W_MSTATUS;
        end
        ST_W_MSTATUS: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= lat_target;
          trap_taken     <= 1'b1;
          state          <= ST_REDIRECT;
        end
        ST_M_MSTATUS: begin
          redirect_valid <= 1'b1;
          redirect_pc    <= lat_target;
          state          <= ST_REDIRECT;
        end
        ST_REDIRECT: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // The core must hold new requests off while a sequence is in flight
  a_no_req_while_busy: assert property (@(posedge clk) disable iff (!rst_n)
    busy |-> !(exc_valid || mret));

endmodule

// File: tb/tb_rv32_mod_trap_ctrl.sv
// Bench for rv32_mod_trap_ctrl: directed vector table, reset corners and random
// transactions against a cycle-level expectation built from the trap rules.
module tb_rv32_mod_trap_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        exc_valid, mret;
  logic [3:0]  exc_cause;
  logic [31:0] exc_pc, exc_tval, irq_pc;
  logic [31:0] csr_mstatus, csr_mie, csr_mip, csr_mtvec, csr_mepc;

  logic        wr_v, busy_v, rv_v, tt_v, wr_d, busy_d, rv_d, tt_d;
  logic [11:0] addr_v, addr_d;
  logic [31:0] wd_v, wd_d, rpc_v, rpc_d;

  rv32_mod_trap_ctrl #(.VECTORED_EN(1'b1)) u_dut_v (
    .clk(clk), .rst_n(rst_n), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .mret(mret), .irq_pc(irq_pc),
    .csr_mstatus(csr_mstatus), .csr_mie(csr_mie), .csr_mip(csr_mip),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .csr_wr(wr_v), .csr_addr(addr_v), .csr_wdata(wd_v), .busy(busy_v),
    .redirect_valid(rv_v), .redirect_pc(rpc_v), .trap_taken(tt_v));

  rv32_mod_trap_ctrl #(.VECTORED_EN(1'b0)) u_dut_d (
    .clk(clk), .rst_n(rst_n), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .mret(mret), .irq_pc(irq_pc),
    .csr_mstatus(csr_mstatus), .csr_mie(csr_mie), .csr_mip(csr_mip),
    .csr_mtvec(csr_mtvec), .csr_mepc(csr_mepc),
    .csr_wr(wr_d), .csr_addr(addr_d), .csr_wdata(wd_d), .busy(busy_d),
    .redirect_valid(rv_d), .redirect_pc(rpc_d), .trap_taken(tt_d));

  // kind: 0 = nothing accepted, 1 = trap entry, 2 = MRET
  typedef struct {
    bit          exc;
    logic [3:0]  cause;
    logic [31:0] pc, tval;
    bit          mret;
    logic [31:0] irq_pc, mst, mie, mip, mtvec, mepc;
    int          kind;
    logic [31:0] e_mepc, e_mcause, e_mtval, e_mst, e_rpc_v, e_rpc_d;
  } vec_t;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic exp_cycle(input string tag, input bit wr, input logic [11:0] addr,
                           input logic [31:0] data, input bit bsy, input bit rv,
                           input bit tt, input logic [31:0] pv, input logic [31:0] pd);
    chk({tag, ".wr_v"}, 32'(wr_v), 32'(wr));
    chk({tag, ".wr_d"}, 32'(wr_d), 32'(wr));
    chk({tag, ".busy"}, 32'({busy_v, busy_d}), 32'({bsy, bsy}));
    chk({tag, ".redir"}, 32'({rv_v, rv_d}), 32'({rv, rv}));
    chk({tag, ".taken"}, 32'({tt_v, tt_d}), 32'({tt, tt}));
    if (wr) begin
      chk({tag, ".addr"}, 32'(addr_v), 32'(addr));
      chk({tag, ".data_v"}, wd_v, data);
      chk({tag, ".data_d"}, wd_d, data);
    end
    if (rv) begin
      chk({tag, ".pc_v"}, rpc_v, pv);
      chk({tag, ".pc_d"}, rpc_d, pd);
    end
  endtask

  // Expected outcome from the architectural trap rules
  function automatic vec_t model(input vec_t v);
    vec_t r;
    logic [31:0] pend, base;
    int code;
    r = v;
    r.kind = 0;
    r.e_mepc = 0; r.e_mcause = 0; r.e_mtval = 0; r.e_mst = 0; r.e_rpc_v = 0; r.e_rpc_d = 0;
    pend = v.mip & v.mie;
    base = v.mtvec & ~32'h3;
    code = -1;
    if (v.mst[3]) begin
      if (pend[11]) code = 11;
      else if (pend[3]) code = 3;
      else if (pend[7]) code = 7;
    end
    if (v.exc) begin
      r.kind = 1; r.e_mepc = v.pc; r.e_mcause = 32'(v.cause); r.e_mtval = v.tval;
      r.e_rpc_v = base; r.e_rpc_d = base;
    end else if (v.mret) begin
      r.kind = 2;
      r.e_mst = (v.mst & ~32'h1888) | 32'h1880 | (v.mst[7] ? 32'h8 : 32'h0);
      r.e_rpc_v = v.mepc; r.e_rpc_d = v.mepc;
    end else if (code >= 0) begin
      r.kind = 1; r.e_mepc = v.irq_pc; r.e_mcause = 32'h8000_0000 + 32'(code); r.e_mtval = 0;
      r.e_rpc_d = base;
      r.e_rpc_v = (v.mtvec[1:0] == 2'b01) ? base + 32'(4 * code) : base;
    end
    if (r.kind == 1)
      r.e_mst = (v.mst & ~32'h1888) | 32'h1800 | (v.mst[3] ? 32'h80 : 32'h0);
    return r;
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle
  task automatic apply(input vec_t v, input string tag);
    logic [11:0] a [4];
    logic [31:0] d [4];
    exc_valid = v.exc; exc_cause = v.cause; exc_pc = v.pc; exc_tval = v.tval;
    mret = v.mret; irq_pc = v.irq_pc; csr_mstatus = v.mst; csr_mie = v.mie;
    csr_mip = v.mip; csr_mtvec = v.mtvec; csr_mepc = v.mepc;
    step();
    exc_valid = 1'b0; mret = 1'b0;
    if (v.kind == 1) begin
      a = '{12'h341, 12'h342, 12'h343, 12'h300};
      d = '{v.e_mepc, v.e_mcause, v.e_mtval, v.e_mst};
      for (int i = 0; i < 4; i++) begin
        exp_cycle($sformatf("%s/w%0d", tag, i), 1, a[i], d[i], 1, 0, 0, 0, 0);
        step();
      end
      exp_cycle({tag, "/redir"}, 0, 0, 0, 1, 1, 1, v.e_rpc_v, v.e_rpc_d);
      step();
      exp_cycle({tag, "/idle"}, 0, 0, 0, 0, 0, 0, 0, 0);
    end else if (v.kind == 2) begin
      exp_cycle({tag, "/mst"}, 1, 12'h300, v.e_mst, 1, 0, 0, 0, 0);
      step();
      exp_cycle({tag, "/redir"}, 0, 0, 0, 1, 1, 0, v.e_rpc_v, v.e_rpc_d);
      step();
      exp_cycle({tag, "/idle"}, 0, 0, 0, 0, 0, 0, 0, 0);
    end else begin
      exp_cycle({tag, "/none"}, 0, 0, 0, 0, 0, 0, 0, 0);
    end
  endtask

  vec_t tbl[12];
  vec_t rv;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // fields: exc,cause,pc,tval,mret,irq_pc,mst,mie,mip,mtvec,mepc, kind,e_mepc,e_mcause,e_mtval,e_mst,e_rpc_v,e_rpc_d
    tbl[0]  = '{1, 4'd2, 32'h100, 32'hDEADBEEF, 0, 32'h0, 32'h88, 32'h0, 32'h0, 32'h10000, 32'h0,
                1, 32'h100, 32'h2, 32'hDEADBEEF, 32'h1880, 32'h10000, 32'h10000};
    tbl[1]  = '{0, 4'd0, 32'h0, 32'h0, 0, 32'h200, 32'h08, 32'h80, 32'h80, 32'h10001, 32'h0,
                1, 32'h200, 32'h80000007, 32'h0, 32'h1880, 32'h1001C, 32'h10000};
    tbl[2]  = '{0, 4'd0, 32'h0, 32'h0, 1, 32'h0, 32'h1880, 32'h0, 32'h0, 32'h10000, 32'h104,
                2, 32'h0, 32'h0, 32'h0, 32'h1888, 32'h104, 32'h104};
    tbl[3]  = '{1, 4'd5, 32'h300, 32'h55, 1, 32'h400, 32'h08, 32'h800, 32'h800, 32'h10001, 32'h104,
                1, 32'h300, 32'h5, 32'h55, 32'h1880, 32'h10000, 32'h10000};
    tbl[4]  = '{0, 4'd0, 32'h0, 32'h0, 0, 32'h400, 32'h1880, 32'h800, 32'h800, 32'h10001, 32'h0,
                0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[5]  = '{0, 4'd0, 32'h0, 32'h0, 0, 32'h500, 32'h08, 32'h888, 32'h888, 32'hFFFFFFFD, 32'h0,
                1, 32'h500, 32'h8000000B, 32'h0, 32'h1880, 32'h28, 32'hFFFFFFFC};
    tbl[6]  = '{0, 4'd0, 32'h0, 32'h0, 0, 32'h600, 32'h88, 32'hFF, 32'h88, 32'h20001, 32'h0,
                1, 32'h600, 32'h80000003, 32'h0, 32'h1880, 32'h2000C, 32'h20000};
    tbl[7]  = '{0, 4'd0, 32'h0, 32'h0, 0, 32'h700, 32'h08, 32'h80, 32'h80, 32'h20002, 32'h0,
                1, 32'h700, 32'h80000007, 32'h0, 32'h1880, 32'h20000, 32'h20000};
    tbl[8]  = '{0, 4'd0, 32'h0, 32'h0, 0, 32'h800, 32'h80, 32'h880, 32'h880, 32'h20001, 32'h0,
                0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[9]  = '{0, 4'd0, 32'h0, 32'h0, 0, 32'h900, 32'h08, 32'hFFFFF777, 32'hFFFFF777, 32'h20001, 32'h0,
                0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0};
    tbl[10] = '{0, 4'd0, 32'h0, 32'h0, 1, 32'h0, 32'h08, 32'h0, 32'h0, 32'h0, 32'hABCDEF00,
                2, 32'h0, 32'h0, 32'h0, 32'h1880, 32'hABCDEF00, 32'hABCDEF00};
    tbl[11] = '{1, 4'd15, 32'hFFFFFFFC, 32'h0, 0, 32'h0, 32'hFFFFFFF7, 32'h0, 32'h0, 32'h80000001, 32'h0,
                1, 32'hFFFFFFFC, 32'hF, 32'h0, 32'hFFFFFF77, 32'h80000000, 32'h80000000};

    // Reset held with a request and a pending interrupt active
    rst_n = 1'b1;
    exc_valid = 1'b1; exc_cause = 4'd2; exc_pc = 32'h100; exc_tval = 32'h1;
    mret = 1'b1; irq_pc = 32'h40; csr_mstatus = 32'h8; csr_mie = 32'h888;
    csr_mip = 32'h888; csr_mtvec = 32'h10001; csr_mepc = 32'h44;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("rst%0d.flags", i),
          32'({wr_v, busy_v, rv_v, tt_v, wr_d, busy_d, rv_d, tt_d}), 32'h0);
      chk($sformatf("rst%0d.addr", i), 32'(addr_v), 32'h0);
      chk($sformatf("rst%0d.wdata", i), wd_v, 32'h0);
      chk($sformatf("rst%0d.rpc", i), rpc_v, 32'h0);
    end
    exc_valid = 1'b0; mret = 1'b0; csr_mie = 32'h0;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      exp_cycle($sformatf("post_rst%0d", i), 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // Directed table, applied back-to-back
    for (int i = 0; i < 12; i++) apply(tbl[i], $sformatf("tbl%0d", i));

    // Reset while mcause is being written
    exc_valid = 1'b1; exc_cause = 4'd4; exc_pc = 32'h120; exc_tval = 32'h77;
    csr_mstatus = 32'h8; csr_mie = 32'h0; csr_mip = 32'h0; csr_mtvec = 32'h3000;
    step();
    exc_valid = 1'b0;
    step();
    chk("midrst.wr_before", 32'({wr_v, addr_v}), 32'({1'b1, 12'h342}));
    #2 rst_n = 1'b0;
    #1;
    chk("midrst.drop", 32'({wr_v, busy_v, wr_d, busy_d}), 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("midrst.hold%0d", i), 32'({wr_v, busy_v, rv_v, tt_v}), 32'h0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      exp_cycle($sformatf("midrst.after%0d", i), 0, 0, 0, 0, 0, 0, 0, 0);
    end

    // Random transactions against the reference model
    for (int n = 0; n < 200; n++) begin
      rv.exc    = ($urandom_range(0, 3) == 0);
      rv.cause  = 4'($urandom);
      rv.pc     = $urandom;
      rv.tval   = $urandom;
      rv.mret   = ($urandom_range(0, 3) == 0);
      rv.irq_pc = $urandom;
      rv.mst    = $urandom;
      rv.mie    = $urandom & ($urandom_range(0, 1) ? 32'hFFFFFFFF : 32'h888);
      rv.mip    = $urandom & $urandom;
      rv.mtvec  = $urandom;
      if ($urandom_range(0, 1) == 1) rv.mtvec[1:0] = 2'b01;
      rv.mepc   = $urandom;
      rv = model(rv);
      apply(rv, $sformatf("rnd%0d", n));
    end

    csr_mie = 32'h0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
